// File: rtl/baccarat_sequencer.sv
// Baccarat hand sequencer: a Moore FSM that strobes card loads and resolves the hand.
// Optional natural (8/9) short-cut in CHECK_P is enabled by defining BACCARAT_NATURAL_CHECK_EN.
module baccarat_sequencer (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       done
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StDealP1 = 4'd1,
        StDealD1 = 4'd2,
        StDealP2 = 4'd3,
        StDealD2 = 4'd4,
        StCheckP = 4'd5,
        StDealP3 = 4'd6,
        StCheckD = 4'd7,
        StDealD3 = 4'd8,
        StResult = 4'd9,
        StDone   = 4'd10
    } state_e;

    state_e state_q, state_d;
    logic   stood_q, stood_d;
    logic   player_q, player_d;
    logic   dealer_q, dealer_d;

    logic [3:0] ps_sat;
    logic [3:0] ds_sat;
    logic [3:0] p3_val;
    logic       natural;
    logic       banker_draw;

    // Scores above 9 can only come from a faulty datapath; clamp them to 9.
    function automatic logic [3:0] sat_score(input logic [3:0] s);
        return (s > 4'd9) ? 4'd9 : s;
    endfunction

    function automatic logic banker_rule(input logic [3:0] ds, input logic [3:0] v);
        logic draw;
        case (ds)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

    always_comb begin
        ps_sat      = sat_score(pscore);
        ds_sat      = sat_score(dscore);
        // Tens and face cards count as zero.
        p3_val      = (pcard3 <= 4'd9) ? pcard3 : 4'd0;
        banker_draw = banker_rule(ds_sat, p3_val);
`ifdef BACCARAT_NATURAL_CHECK_EN
        natural     = (ps_sat >= 4'd8) || (ds_sat >= 4'd8);
`else
        natural     = 1'b0;
`endif
    end

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            state_q  <= StIdle;
            stood_q  <= 1'b0;
            player_q <= 1'b0;
            dealer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stood_q  <= stood_d;
            player_q <= player_d;
            dealer_q <= dealer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stood_d  = stood_q;
        player_d = player_q;
        dealer_d = dealer_q;
        case (state_q)
            StIdle: begin
                stood_d  = 1'b0;
                player_d = 1'b0;
                dealer_d = 1'b0;
                state_d  = StDealP1;
            end
            StDealP1: state_d = StDealD1;
            StDealD1: state_d = StDealP2;
            StDealP2: state_d = StDealD2;
            StDealD2: state_d = StCheckP;
            StCheckP: begin
                if (natural) begin
                    state_d = StResult;
                end else if (ps_sat <= 4'd5) begin
                    state_d = StDealP3;
                end else begin
                    stood_d = 1'b1;
                    state_d = StCheckD;
                end
            end
            StDealP3: begin
                stood_d = 1'b0;
                state_d = StCheckD;
            end
            StCheckD: begin
                if (stood_q ? (ds_sat <= 4'd5) : banker_draw) begin
                    state_d = StDealD3;
                end else begin
                    state_d = StResult;
                end
            end
            StDealD3: state_d = StResult;
            StResult: begin
                player_d = (ps_sat >= ds_sat);
                dealer_d = (ds_sat >= ps_sat);
                state_d  = StDone;
            end
            StDone:   state_d = StDone;
            default: begin
                stood_d  = 1'b0;
                player_d = 1'b0;
                dealer_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    // Outputs depend only on registered state; lamps are flops written in RESULT.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        done             = 1'b0;
        player_win_light = player_q;
        dealer_win_light = dealer_q;
        case (state_q)
            StDealP1: load_pcard1 = 1'b1;
            StDealD1: load_dcard1 = 1'b1;
            StDealP2: load_pcard2 = 1'b1;
            StDealD2: load_dcard2 = 1'b1;
            StDealP3: load_pcard3 = 1'b1;
            StDealD3: load_dcard3 = 1'b1;
            StDone:   done        = 1'b1;
            default:  done        = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Directed bench for baccarat_sequencer; the bench acts as the card/score datapath.
// Expectations follow BACCARAT_NATURAL_CHECK_EN when it is defined for the build.
module tb_baccarat_sequencer;

    logic       clk;
    logic       resetb;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, done;

    int checks;
    int failures;

`ifdef BACCARAT_NATURAL_CHECK_EN
    localparam logic NatEn = 1'b1;
`else
    localparam logic NatEn = 1'b0;
`endif

    baccarat_sequencer dut (
        .slow_clock       (clk),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] loads;
    logic [8:0] outs;
    assign loads = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
    assign outs  = {loads, player_win_light, dealer_win_light, done};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        resetb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'(outs), 32'h0);
        check_eq("reset_state", 32'(dut.state_q), 32'd0);
        resetb = 1'b0;
    endtask

    // Plays one hand from IDLE; pscore/dscore move to *_after when the third card loads.
    task automatic play_hand(input string tag, input logic [3:0] ps, input logic [3:0] ds,
                             input logic [3:0] pc3, input logic [3:0] ps_after,
                             input logic [3:0] ds_after, input logic exp_p3,
                             input logic exp_d3, input logic exp_pl, input logic exp_dl);
        logic saw_p3, saw_d3, bad;
        logic [5:0] exp_load;
        saw_p3 = 1'b0;
        saw_d3 = 1'b0;
        bad    = 1'b0;
        pscore = ps;
        dscore = ds;
        pcard3 = 4'd0;
        exp_load = 6'b100000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_deal"}, 32'(loads), 32'(exp_load));
            exp_load = exp_load >> 1;
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if ($countones(loads) > 1 || loads[5:2] != 4'b0) bad = 1'b1;
            if (load_pcard3) begin
                saw_p3 = 1'b1;
                pcard3 = pc3;
                pscore = ps_after;
            end
            if (load_dcard3) begin
                saw_d3 = 1'b1;
                dscore = ds_after;
            end
            if (done) break;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_p3"}, 32'(saw_p3), 32'(exp_p3));
        check_eq({tag, "_d3"}, 32'(saw_d3), 32'(exp_d3));
        check_eq({tag, "_lamps"}, {30'd0, player_win_light, dealer_win_light},
                 {30'd0, exp_pl, exp_dl});
        check_eq({tag, "_onehot"}, 32'(bad), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetb   = 1'b1;
        pscore   = 4'd0;
        dscore   = 4'd0;
        pcard3   = 4'd0;

        do_reset();
        // Natural: player 8 vs dealer 3.
        play_hand("natural", 4'd8, 4'd3, 4'd0, 4'd8, 4'd3, 1'b0, !NatEn, 1'b1, 1'b0);

        // DONE hold with scores wandering.
        for (int i = 0; i < 20; i++) begin
            pscore = 4'($urandom_range(0, 15));
            dscore = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            check_eq("done_hold", 32'(outs), 32'(9'b000000_101));
        end

        do_reset();
        play_hand("bank_k", 4'd4, 4'd4, 4'd13, 4'd4, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        do_reset();
        play_hand("bank_5", 4'd4, 4'd4, 4'd5, 4'd9, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        play_hand("tie77", 4'd7, 4'd7, 4'd0, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        do_reset();
        play_hand("d3_v8", 4'd2, 4'd3, 4'd8, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        play_hand("d6_v6", 4'd5, 4'd6, 4'd6, 4'd1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        // Score 12 clamps to 9.
        play_hand("clamp", 4'd12, 4'd4, 4'd0, 4'd12, 4'd4, 1'b0, !NatEn, 1'b1, 1'b0);

        // Reset while DEAL_P3 is active, then a full hand must restart.
        do_reset();
        pscore = 4'd4;
        dscore = 4'd4;
        pcard3 = 4'd0;
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (load_pcard3) begin
                    hit = 1'b1;
                    break;
                end
            end
            check_eq("mid_reach_p3", 32'(hit), 32'd1);
        end
        resetb = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_outs", 32'(outs), 32'h0);
        check_eq("mid_state", 32'(dut.state_q), 32'd0);
        resetb = 1'b0;
        play_hand("restart", 4'd6, 4'd2, 4'd0, 4'd6, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/baccarat_sequencer.md
BACCARAT_SEQUENCER -- requirements
Module: baccarat_sequencer

Interface
REQ-001 SHALL have port: slow_clock  input  1  single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port: resetb  input  1  reset, synchronous and active-high (asserted = 1).
REQ-003 SHALL have port: pscore  input  4  player hand score from the datapath, 0-9.
REQ-004 SHALL have port: dscore  input  4  dealer hand score from the datapath, 0-9.
REQ-005 SHALL have port: pcard3  input  4  player third-card rank from the datapath, 0 = none, 1-13 = A..K.
REQ-006 SHALL have ports: load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3  output  1 each  card-register load strobes.
REQ-007 SHALL have ports: player_win_light, dealer_win_light  output  1 each  result lamps.
REQ-008 SHALL have port: done  output  1  the hand is complete.

Function
REQ-009 SHALL be a Moore FSM: all outputs decode from state only, with no combinational path from any input to any output.
REQ-010 SHALL have these states: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK_P, DEAL_P3, CHECK_D, DEAL_D3, RESULT, DONE.
REQ-011 SHALL assert load_pcard1/dcard1/pcard2/dcard2/pcard3/dcard3 only in DEAL_P1/DEAL_D1/DEAL_P2/DEAL_D2/DEAL_P3/DEAL_D3 respectively; at most one load high in any cycle.
REQ-012 SHALL advance IDLE->DEAL_P1->DEAL_D1->DEAL_P2->DEAL_D2->CHECK_P unconditionally, one state per clock.
REQ-013 SHALL sample pscore/dscore only in CHECK_P, CHECK_D and RESULT, one cycle after the last load, so the datapath's falling-edge register update is settled.
REQ-014 SHALL, in CHECK_P with pscore>=8 or dscore>=8 (natural), go to RESULT.
REQ-015 SHALL, in CHECK_P otherwise: pscore 0-5 -> DEAL_P3; pscore 6-7 -> CHECK_D with "player stood" flag set.
REQ-016 SHALL go DEAL_P3 -> CHECK_D unconditionally, with "player stood" flag clear.
REQ-017 SHALL, in CHECK_D with player stood, go to DEAL_D3 iff dscore<=5, else RESULT.
REQ-018 SHALL, in CHECK_D with player drew, compute v = pcard3 if pcard3<=9 else 0 and go to DEAL_D3 iff: dscore 0-2 any v; 3 and v!=8; 4 and v in 2-7; 5 and v in 4-7; 6 and v in 6-7. dscore 7 stands.
REQ-019 SHALL go DEAL_D3 -> RESULT unconditionally.
REQ-020 SHALL, in RESULT, register the lamps: pscore>dscore -> player only; dscore>pscore -> dealer only; equal -> both. Then go to DONE.
REQ-021 SHALL hold DONE with lamps and done=1 stable and no loads until reset.
REQ-022 SHALL treat an out-of-range score (>9) as 9, and any unreachable state encoding as IDLE.

Reset
REQ-023 SHALL, when resetb=1 at a rising edge, enter IDLE regardless of current state, including mid-deal; the next cycle has all loads, both lamps and done at 0.
REQ-024 SHALL leave IDLE on the first rising edge with resetb=0.

Configuration
REQ-025 SHALL gate natural detection on macro BACCARAT_NATURAL_CHECK_EN.
- Defined: REQ-014 applies.
- Undefined: CHECK_P ignores naturals and applies REQ-015 directly; all other behaviour is identical.

Verification
REQ-026 SHALL have a bench, driving scores as a datapath model, cover the reset sequence: resetb=1 for 2 cycles then 0 -> loads asserted exactly in order p1,d1,p2,d2 on cycles 2-5 after release, one-hot.
REQ-027 SHALL cover the natural case: pscore=8, dscore=3 after 4 cards -> no load_pcard3/dcard3; player_win_light=1, dealer_win_light=0, done=1. With the macro undefined, same stimulus -> still stands (pscore 8 > 5), D3 dealt since dscore 3 <= 5.
REQ-028 SHALL cover the banker-rule case: pscore=4, dscore=4, then pcard3=13 (v=0) -> load_pcard3 then no load_dcard3; repeat with pcard3=5 -> load_dcard3 asserted.
REQ-029 SHALL cover the tie: pscore=dscore=7 after 4 cards -> no third cards; both lamps=1.
REQ-030 SHALL cover reset mid-deal: resetb=1 during DEAL_P3 -> next cycle all outputs 0, state IDLE, and the full sequence restarts from load_pcard1.
REQ-031 SHALL cover DONE hold: 20 extra clocks after done with scores changing -> lamps unchanged, no loads.
